// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC register, one-cycle instruction memory interface, and a
// two-entry output buffer (output + skid) feeding decode over a valid/ready handshake.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [5:0]  id_opcode,
    output logic [5:0]  id_funct,
    output logic [31:0] id_pc_plus4
);

    logic [31:0] pc_q, pc_d;
    logic        inflight_q, inflight_d;
    logic        outValid_q, outValid_d;
    logic [31:0] outInstr_q, outInstr_d;
    logic [31:0] outPc4_q, outPc4_d;
    logic        skidValid_q, skidValid_d;
    logic [31:0] skidInstr_q, skidInstr_d;
    logic [31:0] skidPc4_q, skidPc4_d;
    logic        outFree;
    logic        stallFull;

    // Stop issuing once a returning word would have nowhere to go but the skid slot.
    assign stallFull = inflight_q & outValid_q & ~id_ready;
    assign imem_req  = rst_n & (redirect_valid | (~skidValid_q & ~stallFull));
    assign imem_addr = redirect_valid ? redirect_pc : pc_q;
    assign outFree   = ~outValid_q | id_ready;

    assign id_valid    = outValid_q;
    assign id_instr    = outInstr_q;
    assign id_pc_plus4 = outPc4_q;
    assign id_opcode   = outInstr_q[31:26];
    assign id_funct    = outInstr_q[5:0];

    // While a response is in flight, pc_q already holds its fetch address + 4.
    always_comb begin
        pc_d        = pc_q;
        inflight_d  = 1'b0;
        outValid_d  = outValid_q;
        outInstr_d  = outInstr_q;
        outPc4_d    = outPc4_q;
        skidValid_d = skidValid_q;
        skidInstr_d = skidInstr_q;
        skidPc4_d   = skidPc4_q;

        if (imem_req) begin
            pc_d       = imem_addr + 32'd4;
            inflight_d = 1'b1;
        end

        if (redirect_valid) begin
            outValid_d  = 1'b0;
            skidValid_d = 1'b0;
        end else if (inflight_q) begin
            if (outFree && !skidValid_q) begin
                outValid_d = 1'b1;
                outInstr_d = imem_rdata;
                outPc4_d   = pc_q;
            end else if (outFree) begin
                outValid_d  = 1'b1;
                outInstr_d  = skidInstr_q;
                outPc4_d    = skidPc4_q;
                skidValid_d = 1'b1;
                skidInstr_d = imem_rdata;
                skidPc4_d   = pc_q;
            end else begin
                skidValid_d = 1'b1;
                skidInstr_d = imem_rdata;
                skidPc4_d   = pc_q;
            end
        end else if (outFree) begin
            if (skidValid_q) begin
                outValid_d  = 1'b1;
                outInstr_d  = skidInstr_q;
                outPc4_d    = skidPc4_q;
                skidValid_d = 1'b0;
            end else begin
                outValid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            inflight_q  <= 1'b0;
            outValid_q  <= 1'b0;
            outInstr_q  <= 32'd0;
            outPc4_q    <= 32'd0;
            skidValid_q <= 1'b0;
            skidInstr_q <= 32'd0;
            skidPc4_q   <= 32'd0;
        end else begin
            pc_q        <= pc_d;
            inflight_q  <= inflight_d;
            outValid_q  <= outValid_d;
            outInstr_q  <= outInstr_d;
            outPc4_q    <= outPc4_d;
            skidValid_q <= skidValid_d;
            skidInstr_q <= skidInstr_d;
            skidPc4_q   <= skidPc4_d;
        end
    end

endmodule
